// File: rtl/alu_issue_queue.sv
// ALU issue queue: collapsing reservation station with dual dispatch,
// wakeup tracking and oldest-ready issue. Optional: ALUQ_PERF_CNT_EN.
module alu_issue_queue #(
  parameter int DEPTH     = 8,
  parameter int PAYLOAD_W = 128,
  parameter int PRF_W     = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         wen_0,
  input  logic                         wen_1,
  input  logic [PAYLOAD_W-1:0]         din_0,
  input  logic [PAYLOAD_W-1:0]         din_1,
  input  logic [PRF_W-1:0]             prs1_0,
  input  logic [PRF_W-1:0]             prs2_0,
  input  logic [PRF_W-1:0]             prs1_1,
  input  logic [PRF_W-1:0]             prs2_1,
  input  logic                         prs1_rdy_0,
  input  logic                         prs2_rdy_0,
  input  logic                         prs1_rdy_1,
  input  logic                         prs2_rdy_1,
  input  logic                         wk_valid_0,
  input  logic                         wk_valid_1,
  input  logic [PRF_W-1:0]             wk_tag_0,
  input  logic [PRF_W-1:0]             wk_tag_1,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [PAYLOAD_W-1:0]         issue_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         overflow_err
`ifdef ALUQ_PERF_CNT_EN
  ,
  output logic [31:0]                  stall_cycles,
  output logic [31:0]                  issue_cnt
`endif
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic [PAYLOAD_W-1:0] data;
    logic [PRF_W-1:0]     t1;
    logic [PRF_W-1:0]     t2;
    logic                 r1;
    logic                 r2;
  } ent_t;

  ent_t          q     [DEPTH];
  ent_t          woke  [DEPTH];
  ent_t          nq    [DEPTH];
  ent_t          n0;
  ent_t          n1;
  logic [IW-1:0] sel;
  logic          any;
  logic          do_issue;
  logic          acc0;
  logic          acc1;
  logic          ovf_set;
  logic [CW-1:0] base;
  logic [CW-1:0] n_count;

  function automatic logic hit(
    input logic [PRF_W-1:0] t,
    input logic             v0,
    input logic [PRF_W-1:0] g0,
    input logic             v1,
    input logic [PRF_W-1:0] g1
  );
    return (v0 && g0 == t) || (v1 && g1 == t);
  endfunction

  // oldest ready entry among the occupied slots
  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if ((CW'(i) < count) && q[i].r1 && q[i].r2) begin
        sel = IW'(i);
        any = 1'b1;
      end
    end
  end

  assign issue_valid = any;
  assign issue_data  = any ? q[sel].data : '0;
  assign full        = count > CW'(DEPTH-2);
  assign do_issue    = any && issue_ready;

  // wakeup, collapse on issue, then append new entries
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i]    = q[i];
      woke[i].r1 = q[i].r1 | hit(q[i].t1, wk_valid_0, wk_tag_0,
                                 wk_valid_1, wk_tag_1);
      woke[i].r2 = q[i].r2 | hit(q[i].t2, wk_valid_0, wk_tag_0,
                                 wk_valid_1, wk_tag_1);
      nq[i]      = woke[i];
    end
    for (int i = 0; i < DEPTH-1; i++) begin
      if (do_issue && i >= int'(sel))
        nq[i] = woke[i+1];
    end
    n0.data = din_0;
    n0.t1   = prs1_0;
    n0.t2   = prs2_0;
    n0.r1   = prs1_rdy_0 | hit(prs1_0, wk_valid_0, wk_tag_0,
                               wk_valid_1, wk_tag_1);
    n0.r2   = prs2_rdy_0 | hit(prs2_0, wk_valid_0, wk_tag_0,
                               wk_valid_1, wk_tag_1);
    n1.data = din_1;
    n1.t1   = prs1_1;
    n1.t2   = prs2_1;
    n1.r1   = prs1_rdy_1 | hit(prs1_1, wk_valid_0, wk_tag_0,
                               wk_valid_1, wk_tag_1);
    n1.r2   = prs2_rdy_1 | hit(prs2_1, wk_valid_0, wk_tag_0,
                               wk_valid_1, wk_tag_1);
    base    = count - CW'(do_issue);
    acc0    = wen_0 && (base < CW'(DEPTH));
    acc1    = wen_0 && wen_1 && (base < CW'(DEPTH-1));
    ovf_set = (wen_0 && !acc0) || (wen_0 && wen_1 && !acc1);
    for (int i = 0; i < DEPTH; i++) begin
      if (acc0 && CW'(i) == base)
        nq[i] = n0;
      if (acc1 && CW'(i) == base + CW'(1))
        nq[i] = n1;
    end
    n_count = base + CW'(acc0) + CW'(acc1);
  end

  // queue state; flush wins over issue and dispatch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        q[i] <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else if (flush) begin
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        q[i] <= nq[i];
      count        <= n_count;
      overflow_err <= overflow_err | ovf_set;
    end
  end

`ifdef ALUQ_PERF_CNT_EN
  // free-running performance counters, untouched by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      issue_cnt    <= '0;
    end else begin
      if (count != '0 && !issue_valid)
        stall_cycles <= stall_cycles + 32'd1;
      if (do_issue && !flush)
        issue_cnt <= issue_cnt + 32'd1;
    end
  end
`endif

endmodule
